// File: rtl/st2_imm_extend_pipe_if.sv
// Stage-2 immediate bus: instruction immediate in from decode, registered immediate out to EX.
// master = decode/EX side, slave = the immediate generator.
interface st2_imm_extend_pipe_if #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic [IN_W-1:0]  imm_field;
    logic [2:0]       se_sel;
    logic             stall;
    logic             flush;
    logic             out_valid;
    logic [OUT_W-1:0] out_imm;
    logic             out_prefixed;
    logic             out_illegal;

    modport master (
        output in_valid, imm_field, se_sel, stall, flush,
        input  out_valid, out_imm, out_prefixed, out_illegal
    );

    modport slave (
        input  in_valid, imm_field, se_sel, stall, flush,
        output out_valid, out_imm, out_prefixed, out_illegal
    );
endinterface

// File: rtl/st2_imm_extend_pipe.sv
// Stage-2 immediate generator with prefix-built constants, registered into ID/EX.
// Optional reserved-mode trap enabled by defining ST2_SE_ILLEGAL_TRAP_EN.
//
// state | meaning
// IDLE  | no prefix pending; ops produce their mode's extension
// ARMED | prefix_q holds upper bits; next non-prefix op is combined with them
module st2_imm_extend_pipe #(
    parameter int IN_W     = 12,
    parameter int OUT_W    = 16,
    parameter int PREFIX_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    st2_imm_extend_pipe_if.slave  bus
);

`ifdef ST2_SE_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic {IDLE, ARMED} state_t;

    state_t              state_q, state_d;
    logic [PREFIX_W-1:0] prefix_q, prefix_d;
    logic                valid_q, valid_d;
    logic [OUT_W-1:0]    imm_q, imm_d;
    logic                prefixed_q, prefixed_d;
    logic                illegal_q, illegal_d;

    logic [IN_W-1:0]     f;
    logic [OUT_W-1:0]    ext_imm;
    logic [OUT_W-1:0]    sext8;
    logic                is_prefix;
    logic                is_rsv;
    logic                is_trap;

    assign f         = bus.imm_field;
    assign sext8     = {{(OUT_W-8){f[7]}}, f[7:0]};
    assign is_prefix = (bus.se_sel == 3'b110);
    assign is_rsv    = (bus.se_sel == 3'b111);
    assign is_trap   = is_rsv && TRAP_EN;

    always_comb begin
        ext_imm = {{(OUT_W-IN_W){1'b0}}, f};
        case (bus.se_sel)
            3'b000:  ext_imm = {{(OUT_W-4){f[3]}}, f[3:0]};
            3'b001:  ext_imm = {{(OUT_W-8){1'b0}}, f[7:0]};
            3'b010:  ext_imm = sext8;
            3'b011:  ext_imm = {{(OUT_W-IN_W){f[IN_W-1]}}, f};
            3'b100:  ext_imm = {sext8[OUT_W-2:0], 1'b0};
            default: ext_imm = {{(OUT_W-IN_W){1'b0}}, f};
        endcase
    end

    always_comb begin
        state_d    = state_q;
        prefix_d   = prefix_q;
        valid_d    = valid_q;
        imm_d      = imm_q;
        prefixed_d = prefixed_q;
        illegal_d  = illegal_q;
        if (bus.flush) begin
            valid_d    = 1'b0;
            prefixed_d = 1'b0;
            illegal_d  = 1'b0;
            state_d    = IDLE;
            prefix_d   = '0;
        end else if (!bus.stall) begin
            valid_d    = 1'b0;
            prefixed_d = 1'b0;
            illegal_d  = 1'b0;
            if (bus.in_valid) begin
                if (is_prefix) begin
                    prefix_d = f[PREFIX_W-1:0];
                    state_d  = ARMED;
                end else if (is_trap) begin
                    valid_d   = 1'b1;
                    imm_d     = '0;
                    illegal_d = 1'b1;
                end else if (state_q == ARMED) begin
                    valid_d    = 1'b1;
                    prefixed_d = 1'b1;
                    imm_d      = {prefix_q, f[OUT_W-PREFIX_W-1:0]};
                    // the reserved mode never moves the state, so the prefix stays armed
                    if (!is_rsv) state_d = IDLE;
                end else begin
                    valid_d = 1'b1;
                    imm_d   = ext_imm;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prefix_q   <= '0;
            valid_q    <= 1'b0;
            imm_q      <= '0;
            prefixed_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prefix_q   <= prefix_d;
            valid_q    <= valid_d;
            imm_q      <= imm_d;
            prefixed_q <= prefixed_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.out_imm      = imm_q;
    assign bus.out_prefixed = prefixed_q;
    assign bus.out_illegal  = illegal_q;

endmodule

// File: tb/tb_st2_imm_extend_pipe.sv
// Directed bench for st2_imm_extend_pipe: modes, prefix sequences, stall/flush, reset, reserved mode.
module tb_st2_imm_extend_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    st2_imm_extend_pipe_if #(.IN_W(12), .OUT_W(16)) bus ();

    st2_imm_extend_pipe #(.IN_W(12), .OUT_W(16), .PREFIX_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [2:0] s, input logic [11:0] f,
                         input logic st, input logic fl);
        bus.in_valid  = v;
        bus.se_sel    = s;
        bus.imm_field = f;
        bus.stall     = st;
        bus.flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 3'b011, 12'hF01, 1'b0, 1'b0);
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
        vectors++;
        if (bus.out_imm !== 16'h0000) begin miscompares++; $display("FAIL reset_imm got %h exp 0000", bus.out_imm); end
        vectors++;
        if (bus.out_prefixed !== 1'b0) begin miscompares++; $display("FAIL reset_prefixed got %b exp 0", bus.out_prefixed); end
        vectors++;
        if (bus.out_illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal got %b exp 0", bus.out_illegal); end
        rst_n = 1'b1;
    endtask

    task automatic test_modes();
        logic [2:0]  sel_t [8] = '{3'b011, 3'b000, 3'b001, 3'b010, 3'b100, 3'b100, 3'b101, 3'b000};
        logic [11:0] fld_t [8] = '{12'hF01, 12'h008, 12'hF7C, 12'hFAC, 12'hF7C, 12'hFAC, 12'hF7C, 12'h007};
        logic [15:0] exp_t [8] = '{16'hFF01, 16'hFFF8, 16'h007C, 16'hFFAC, 16'h00F8, 16'hFF58, 16'h0F7C, 16'h0007};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, sel_t[i], fld_t[i], 1'b0, 1'b0);
            tick();
            vectors++;
            if (bus.out_imm !== exp_t[i]) begin
                miscompares++;
                $display("FAIL mode%0d_imm sel %b got %h exp %h", i, sel_t[i], bus.out_imm, exp_t[i]);
            end
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_prefixed !== 1'b0) begin
                miscompares++;
                $display("FAIL mode%0d_flags got v=%b p=%b exp v=1 p=0", i, bus.out_valid, bus.out_prefixed);
            end
        end
    endtask

    task automatic test_bubble();
        drive(1'b0, 3'b011, 12'h123, 1'b0, 1'b0);
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_imm !== 16'h0007) begin
            miscompares++;
            $display("FAIL bubble got v=%b imm=%h exp v=0 imm=0007", bus.out_valid, bus.out_imm);
        end
    endtask

    task automatic test_prefix();
        drive(1'b1, 3'b110, 12'h0AB, 1'b0, 1'b0);
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL prefix_slot got %b exp 0", bus.out_valid); end
        drive(1'b0, 3'b010, 12'h0CD, 1'b0, 1'b0);
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL prefix_bubble got %b exp 0", bus.out_valid); end
        drive(1'b1, 3'b010, 12'h0CD, 1'b0, 1'b0);
        tick();
        vectors++;
        if (bus.out_imm !== 16'hABCD || bus.out_prefixed !== 1'b1 || bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL prefix_combine got imm=%h p=%b v=%b exp ABCD 1 1", bus.out_imm, bus.out_prefixed, bus.out_valid);
        end
        tick();
        vectors++;
        if (bus.out_imm !== 16'hFFCD || bus.out_prefixed !== 1'b0) begin
            miscompares++;
            $display("FAIL prefix_after got imm=%h p=%b exp FFCD 0", bus.out_imm, bus.out_prefixed);
        end
        // overwrite: second prefix replaces the first
        drive(1'b1, 3'b110, 12'h0AB, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'b110, 12'h012, 1'b0, 1'b0);
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL prefix_overwrite_slot got %b exp 0", bus.out_valid); end
        drive(1'b1, 3'b001, 12'hF34, 1'b0, 1'b0);
        tick();
        vectors++;
        if (bus.out_imm !== 16'h1234 || bus.out_prefixed !== 1'b1) begin
            miscompares++;
            $display("FAIL prefix_overwrite got imm=%h p=%b exp 1234 1", bus.out_imm, bus.out_prefixed);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 3'b011, 12'hF01, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(i[0], (i == 1) ? 3'b110 : 3'b000, (i == 2) ? 12'h008 : 12'h0AB, 1'b1, 1'b0);
            tick();
            vectors++;
            if (bus.out_imm !== 16'hFF01 || bus.out_valid !== 1'b1 || bus.out_prefixed !== 1'b0) begin
                miscompares++;
                $display("FAIL stall%0d got imm=%h v=%b p=%b exp FF01 1 0", i, bus.out_imm, bus.out_valid, bus.out_prefixed);
            end
        end
        // prefix op under stall must not have armed anything
        drive(1'b1, 3'b010, 12'h0CD, 1'b0, 1'b0);
        tick();
        vectors++;
        if (bus.out_imm !== 16'hFFCD || bus.out_prefixed !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release got imm=%h p=%b exp FFCD 0", bus.out_imm, bus.out_prefixed);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 3'b001, 12'hF7C, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'b110, 12'h0AB, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'b010, 12'h0CD, 1'b1, 1'b1);
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_prefixed !== 1'b0 || bus.out_imm !== 16'h007C) begin
            miscompares++;
            $display("FAIL flush got v=%b p=%b imm=%h exp 0 0 007C", bus.out_valid, bus.out_prefixed, bus.out_imm);
        end
        drive(1'b1, 3'b010, 12'h0CD, 1'b0, 1'b0);
        tick();
        vectors++;
        if (bus.out_imm !== 16'hFFCD || bus.out_prefixed !== 1'b0 || bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_clears_prefix got imm=%h p=%b v=%b exp FFCD 0 1", bus.out_imm, bus.out_prefixed, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_prefix();
        drive(1'b1, 3'b110, 12'h0AB, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        drive(1'b1, 3'b011, 12'hF01, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_imm !== 16'h0000 || bus.out_prefixed !== 1'b0 || bus.out_illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset got v=%b imm=%h p=%b i=%b exp all 0", bus.out_valid, bus.out_imm, bus.out_prefixed, bus.out_illegal);
        end
        drive(1'b1, 3'b010, 12'h0CD, 1'b0, 1'b0);
        tick();
        vectors++;
        if (bus.out_imm !== 16'hFFCD || bus.out_prefixed !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_idle got imm=%h p=%b exp FFCD 0", bus.out_imm, bus.out_prefixed);
        end
    endtask

    task automatic test_reserved();
        drive(1'b1, 3'b111, 12'h123, 1'b0, 1'b0);
        tick();
`ifdef ST2_SE_ILLEGAL_TRAP_EN
        vectors++;
        if (bus.out_illegal !== 1'b1 || bus.out_imm !== 16'h0000 || bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rsv_trap got i=%b imm=%h v=%b exp 1 0000 1", bus.out_illegal, bus.out_imm, bus.out_valid);
        end
        drive(1'b1, 3'b110, 12'h0AB, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'b111, 12'h123, 1'b0, 1'b0);
        tick();
        vectors++;
        if (bus.out_illegal !== 1'b1 || bus.out_prefixed !== 1'b0) begin
            miscompares++;
            $display("FAIL rsv_trap_armed got i=%b p=%b exp 1 0", bus.out_illegal, bus.out_prefixed);
        end
        drive(1'b1, 3'b010, 12'h0CD, 1'b0, 1'b0);
        tick();
        vectors++;
        if (bus.out_imm !== 16'hABCD || bus.out_prefixed !== 1'b1 || bus.out_illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL rsv_trap_keeps_prefix got imm=%h p=%b i=%b exp ABCD 1 0", bus.out_imm, bus.out_prefixed, bus.out_illegal);
        end
`else
        vectors++;
        if (bus.out_imm !== 16'h0123 || bus.out_illegal !== 1'b0 || bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rsv_zext got imm=%h i=%b v=%b exp 0123 0 1", bus.out_imm, bus.out_illegal, bus.out_valid);
        end
        drive(1'b1, 3'b111, 12'hFED, 1'b0, 1'b0);
        tick();
        vectors++;
        if (bus.out_imm !== 16'h0FED || bus.out_illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL rsv_zext2 got imm=%h i=%b exp 0FED 0", bus.out_imm, bus.out_illegal);
        end
`endif
    endtask

    initial begin
        drive(1'b0, 3'b000, 12'h000, 1'b0, 1'b0);
        test_reset();
        test_modes();
        test_bubble();
        test_prefix();
        test_stall();
        test_flush();
        test_reset_mid_prefix();
        test_reserved();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
